frac_lutk_cfg: RTL and testbench
================================

FRAC_LUTK_CFG -- requirements
Module: frac_lutk_cfg

Interface
REQ-001 SHALL have parameter K, default 6, meaning LUT input count; legal range 2..6.
REQ-002 SHALL derive localparams T = 2^K (truth-table bits) and N = T+1 (chain length: T table bits plus 1 mode bit).
REQ-003 SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-004 prog_clk  input  1  configuration clock; all state updates on its rising edge.
REQ-005 pReset  input  1  asynchronous active-high reset.
REQ-006 cfg_en  input  1  shift enable; one chain bit per prog_clk edge while high.
REQ-007 ccff_head  input  1  serial configuration data in.
REQ-008 cfg_parity  input  1  expected XOR of all N loaded bits, sampled on the final shift edge.
REQ-009 in  input  K  LUT address inputs; in[0] is the address LSB.
REQ-010 ccff_tail  output  1  serial data out; equals the mode bit (last chain stage).
REQ-011 cfg_done  output  1  high when a complete N-bit load has finished.
REQ-012 cfg_err  output  1  parity mismatch flag for the last completed load.
REQ-013 lutk_out  output  1  K-input LUT result.
REQ-014 lutkm1_out  output  2  the two (K-1)-input fractured results.

Function
REQ-015 SHALL hold the chain as table[0..T-1] plus mode; on each shift: table[0] <= ccff_head, table[i] <= table[i-1], mode <= table[T-1].
REQ-016 SHALL implement FSM states UNCFG, LOAD, DONE, plus a bit counter cnt of width clog2(N+1).
REQ-017 UNCFG or DONE with cfg_en=1: shift, set cnt=1, clear cfg_done and cfg_err, go to LOAD; cfg_en=0: hold all state.
REQ-018 LOAD with cfg_en=0: hold chain, cnt and parity (pause allowed, no timeout).
REQ-019 LOAD with cfg_en=1 and cnt<N-1: shift, cnt+1.
REQ-020 LOAD with cfg_en=1 and cnt=N-1: shift, cnt=N, go to DONE, cfg_done=1 in the next cycle.
REQ-021 SHALL keep a running parity p (XOR of the bits shifted in), cleared on load start; on the final shift, cfg_err <= (p XOR ccff_head) != cfg_parity.
REQ-022 Let sel_top = in[K-1] OR mode, and let a = in[K-2:0].
REQ-023 lutkm1_out[0] SHALL equal table[a]; lutkm1_out[1] SHALL equal table[T/2 + a].
REQ-024 lutk_out SHALL equal lutkm1_out[sel_top]; mode=1 therefore forces the upper half (dual-LUT mode).
REQ-025 LUT outputs SHALL be combinational from in and the stored table.
REQ-026 lutk_out and lutkm1_out SHALL be forced to 0 whenever cfg_done=0, including during a reload.
REQ-027 ccff_tail SHALL reflect the mode register at all times, including during LOAD, to allow daisy-chaining and readback.
REQ-028 Additional bits shifted after DONE start a new load (REQ-017); no bit is ever dropped.

Reset
REQ-029 pReset=1 SHALL immediately clear the following: table, mode, cnt, p, state=UNCFG, cfg_done=0, cfg_err=0, ccff_tail=0, and all LUT outputs to 0.
REQ-030 Reset asserted mid-LOAD SHALL discard partial data; the next load restarts from cnt=0.
REQ-031 Deassertion SHALL be honoured asynchronously; the first shift occurs on the first prog_clk edge with pReset=0 and cfg_en=1.

Verification
REQ-032 K=6, shift 65 bits encoding an AND2 table (table[3]=1, all others 0, mode=0) with correct parity -> cfg_done=1 after edge 65, cfg_err=0; in=000011 -> lutk_out=1; in=000001 -> 0.
REQ-033 K=6, table with lower half 0xAAAA_AAAA, upper half 0xFFFF_0000, mode=1 -> lutkm1_out[0]=in[0]; lutkm1_out[1]=in[4]; lutk_out=lutkm1_out[1] for in[5]=0.
REQ-034 K=4, 17 bits with cfg_en low for 3 cycles mid-stream -> loaded table identical to the unpaused load; cfg_done is asserted only after the 17th enabled edge.
REQ-035 K=6, wrong cfg_parity on the final bit -> cfg_err=1, cfg_done=1; a new load clears cfg_err on its first shift edge.
REQ-036 K=6, pReset pulsed after 30 shifts -> cfg_done=0, outputs 0, ccff_tail=0; a subsequent full 65-bit load behaves per REQ-032.
REQ-037 K=4, after DONE shift 17 more bits -> ccff_tail emits the previous chain contents mode-first (readback order), then cfg_done reasserts with the new table.

Source files
------------

// File: rtl/frac_lutk_cfg.sv
// Fracturable K-input LUT with a serial configuration chain (T table bits + mode bit),
// load sequencing with parity check, and readback through ccff_tail.
module frac_lutk_cfg #(
  parameter int unsigned K = 6
) (
  input  logic         prog_clk,
  input  logic         pReset,
  input  logic         cfg_en,
  input  logic         ccff_head,
  input  logic         cfg_parity,
  input  logic [K-1:0] in,
  output logic         ccff_tail,
  output logic         cfg_done,
  output logic         cfg_err,
  output logic         lutk_out,
  output logic [1:0]   lutkm1_out
);

  localparam int unsigned T  = 1 << K;
  localparam int unsigned N  = T + 1;
  localparam int unsigned CW = $clog2(N + 1);
  localparam int unsigned AW = K - 1;

  typedef enum logic [1:0] {
    UNCFG = 2'd0,
    LOAD  = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [T-1:0]    lut_table;
  logic            mode;
  logic [CW-1:0]   cnt;
  logic            par_run;

  logic            shift_c;
  logic            start_c;
  logic            last_c;

  logic [AW-1:0]   addr_c;
  logic            lo_bit_c;
  logic            hi_bit_c;
  logic            sel_top_c;

  // State register
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      state <= UNCFG;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      UNCFG, DONE: begin
        if (cfg_en) state_next = LOAD;
      end
      LOAD: begin
        if (cfg_en && (cnt == CW'(N - 1))) state_next = DONE;
      end
      default: state_next = UNCFG;
    endcase
  end

  // Per-state control strobes for the datapath
  always_comb begin
    shift_c = 1'b0;
    start_c = 1'b0;
    last_c  = 1'b0;
    case (state)
      UNCFG, DONE: begin
        shift_c = cfg_en;
        start_c = cfg_en;
      end
      LOAD: begin
        shift_c = cfg_en;
        last_c  = cfg_en && (cnt == CW'(N - 1));
      end
      default: begin
        shift_c = 1'b0;
      end
    endcase
  end

  // Configuration chain: head enters table[0], table[T-1] moves into mode
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      lut_table <= '0;
      mode      <= 1'b0;
    end else if (shift_c) begin
      lut_table <= {lut_table[T-2:0], ccff_head};
      mode      <= lut_table[T-1];
    end
  end

  // Bit counter, running parity and status flags
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cnt      <= '0;
      par_run  <= 1'b0;
      cfg_err  <= 1'b0;
      cfg_done <= 1'b0;
    end else begin
      if (start_c) begin
        cnt     <= CW'(1);
        par_run <= ccff_head;
        cfg_err <= 1'b0;
      end else if (shift_c) begin
        cnt     <= cnt + CW'(1);
        par_run <= par_run ^ ccff_head;
        if (last_c) cfg_err <= (par_run ^ ccff_head) != cfg_parity;
      end
      cfg_done <= (state_next == DONE);
    end
  end

  assign ccff_tail = mode;

  // Fractured lookup: two (K-1)-input halves, mode steers the K-input result to the upper half
  assign addr_c     = in[AW-1:0];
  assign lo_bit_c   = lut_table[{1'b0, addr_c}];
  assign hi_bit_c   = lut_table[{1'b1, addr_c}];
  assign sel_top_c  = in[K-1] | mode;
  assign lutkm1_out = cfg_done ? {hi_bit_c, lo_bit_c} : 2'b00;
  assign lutk_out   = cfg_done & (sel_top_c ? hi_bit_c : lo_bit_c);

endmodule

// File: tb/tb_frac_lutk_cfg.sv
// Bench for frac_lutk_cfg: K=6 and K=4 instances checked against a stream-level model
// (chain vector c, c[N-1] = mode sent first, c[T-1:0] = table).
module tb_frac_lutk_cfg;

  logic prog_clk = 1'b0;
  logic pReset   = 1'b1;

  logic       cfg_en6 = 1'b0, head6 = 1'b0, par6 = 1'b0;
  logic [5:0] in6 = '0;
  logic       tail6, done6, err6, lutk6;
  logic [1:0] km6;

  logic       cfg_en4 = 1'b0, head4 = 1'b0, par4 = 1'b0;
  logic [3:0] in4 = '0;
  logic       tail4, done4, err4, lutk4;
  logic [1:0] km4;

  int n_tests = 0;
  int n_fail  = 0;

  logic [16:0] c4_cur;

  always #5 prog_clk = ~prog_clk;

  frac_lutk_cfg #(.K(6)) u6 (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_en(cfg_en6), .ccff_head(head6),
    .cfg_parity(par6), .in(in6), .ccff_tail(tail6), .cfg_done(done6),
    .cfg_err(err6), .lutk_out(lutk6), .lutkm1_out(km6)
  );

  frac_lutk_cfg #(.K(4)) u4 (
    .prog_clk(prog_clk), .pReset(pReset), .cfg_en(cfg_en4), .ccff_head(head4),
    .cfg_parity(par4), .in(in4), .ccff_tail(tail4), .cfg_done(done4),
    .cfg_err(err4), .lutk_out(lutk4), .lutkm1_out(km4)
  );

  // Reference: {lutk, upper half result, lower half result} from the loaded chain
  function automatic logic [2:0] ref6(input logic [64:0] c, input logic [5:0] a);
    int lo, hi;
    logic sel;
    lo  = int'(a[4:0]);
    hi  = lo + 32;
    sel = a[5] | c[64];
    return {sel ? c[hi] : c[lo], c[hi], c[lo]};
  endfunction

  function automatic logic [2:0] ref4(input logic [16:0] c, input logic [3:0] a);
    int lo, hi;
    logic sel;
    lo  = int'(a[2:0]);
    hi  = lo + 8;
    sel = a[3] | c[16];
    return {sel ? c[hi] : c[lo], c[hi], c[lo]};
  endfunction

  function automatic logic [64:0] rand65();
    return 65'({$urandom(), $urandom(), $urandom()});
  endfunction

  // Send stream positions from..to (position p carries c[N-1-p]); ends at a negedge with cfg_en low
  task automatic send6(input logic [64:0] c, input int from, input int to, input logic par);
    for (int p = from; p <= to; p++) begin
      @(negedge prog_clk);
      cfg_en6 = 1'b1;
      head6   = c[64-p];
      par6    = par;
    end
    @(negedge prog_clk);
    cfg_en6 = 1'b0;
  endtask

  task automatic send4(input logic [16:0] c, input int from, input int to, input logic par);
    for (int p = from; p <= to; p++) begin
      @(negedge prog_clk);
      cfg_en4 = 1'b1;
      head4   = c[16-p];
      par4    = par;
    end
    @(negedge prog_clk);
    cfg_en4 = 1'b0;
  endtask

  task automatic test_reset();
    in6 = 6'h3f;
    in4 = 4'hf;
    #2;
    n_tests++;
    if ({done6, err6, tail6, lutk6, km6} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset6: got %b want 000000", {done6, err6, tail6, lutk6, km6});
    end
    n_tests++;
    if ({done4, err4, tail4, lutk4, km4} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset4: got %b want 000000", {done4, err4, tail4, lutk4, km4});
    end
    @(negedge prog_clk);
    pReset = 1'b0;
  endtask

  task automatic load_and2_check(input string tag);
    logic [64:0] c;
    c    = '0;
    c[3] = 1'b1;
    send6(c, 0, 63, ^c);
    n_tests++;
    if (done6 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_done_early: got %b want 0", tag, done6);
    end
    send6(c, 64, 64, ^c);
    n_tests++;
    if ({done6, err6} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s_status: done/err got %b want 10", tag, {done6, err6});
    end
    in6 = 6'b000011;
    #1;
    n_tests++;
    if (lutk6 !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_in03: got %b want 1", tag, lutk6);
    end
    in6 = 6'b000001;
    #1;
    n_tests++;
    if (lutk6 !== 1'b0) begin
      n_fail++;
      $display("FAIL %s_in01: got %b want 0", tag, lutk6);
    end
  endtask

  task automatic test_and2();
    load_and2_check("and2");
  endtask

  task automatic test_dual_mode();
    logic [64:0] c;
    c[31:0]  = 32'hAAAA_AAAA;
    c[63:32] = 32'hFFFF_0000;
    c[64]    = 1'b1;
    send6(c, 0, 64, ^c);
    for (int i = 0; i < 24; i++) begin
      in6 = 6'($urandom_range(0, 63));
      #1;
      n_tests++;
      if ({km6, lutk6} !== {in6[4], in6[0], in6[4]}) begin
        n_fail++;
        $display("FAIL dual in=%b: km/lutk got %b want %b", in6, {km6, lutk6}, {in6[4], in6[0], in6[4]});
      end
    end
  endtask

  task automatic test_random6();
    logic [64:0] c;
    logic [2:0]  exp;
    for (int l = 0; l < 4; l++) begin
      c = rand65();
      send6(c, 0, 64, ^c);
      n_tests++;
      if ({done6, err6, tail6} !== {2'b10, c[64]}) begin
        n_fail++;
        $display("FAIL rand6_status l=%0d: got %b want %b", l, {done6, err6, tail6}, {2'b10, c[64]});
      end
      for (int i = 0; i < 16; i++) begin
        in6 = 6'($urandom_range(0, 63));
        #1;
        exp = ref6(c, in6);
        n_tests++;
        if ({lutk6, km6} !== exp) begin
          n_fail++;
          $display("FAIL rand6_lut l=%0d in=%b: got %b want %b", l, in6, {lutk6, km6}, exp);
        end
      end
    end
  endtask

  task automatic test_parity_err();
    logic [64:0] c, c2;
    c  = rand65();
    c2 = rand65();
    send6(c, 0, 64, ~(^c));
    n_tests++;
    if ({done6, err6} !== 2'b11) begin
      n_fail++;
      $display("FAIL perr_flag: done/err got %b want 11", {done6, err6});
    end
    send6(c2, 0, 0, 1'b0);
    n_tests++;
    if ({done6, err6, lutk6, km6} !== 5'b0) begin
      n_fail++;
      $display("FAIL perr_clear: done/err/lut got %b want 00000", {done6, err6, lutk6, km6});
    end
    send6(c2, 1, 64, ^c2);
    n_tests++;
    if ({done6, err6} !== 2'b10) begin
      n_fail++;
      $display("FAIL perr_reload: done/err got %b want 10", {done6, err6});
    end
  endtask

  task automatic test_reset_mid_load();
    logic [64:0] c_all, c_new;
    c_all = '1;
    c_new = rand65();
    send6(c_all, 0, 64, ^c_all);
    send6(c_new, 0, 29, 1'b0);
    n_tests++;
    if ({done6, tail6} !== 2'b01) begin
      n_fail++;
      $display("FAIL midload_pre: done/tail got %b want 01", {done6, tail6});
    end
    in6 = 6'h3f;
    #2;
    pReset = 1'b1;
    #1;
    n_tests++;
    if ({done6, err6, tail6, lutk6, km6} !== 6'b0) begin
      n_fail++;
      $display("FAIL midload_reset: got %b want 000000", {done6, err6, tail6, lutk6, km6});
    end
    @(negedge prog_clk);
    pReset = 1'b0;
    load_and2_check("after_reset");
  endtask

  task automatic test_pause4();
    logic [16:0] c;
    logic [2:0]  exp;
    c = 17'($urandom());
    send4(c, 0, 7, ^c);
    repeat (2) @(negedge prog_clk);
    n_tests++;
    if (done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL pause4_mid: done got %b want 0", done4);
    end
    send4(c, 8, 15, ^c);
    n_tests++;
    if (done4 !== 1'b0) begin
      n_fail++;
      $display("FAIL pause4_early: done got %b want 0", done4);
    end
    send4(c, 16, 16, ^c);
    n_tests++;
    if ({done4, err4, tail4} !== {2'b10, c[16]}) begin
      n_fail++;
      $display("FAIL pause4_status: got %b want %b", {done4, err4, tail4}, {2'b10, c[16]});
    end
    for (int a = 0; a < 16; a++) begin
      in4 = 4'(a);
      #1;
      exp = ref4(c, in4);
      n_tests++;
      if ({lutk4, km4} !== exp) begin
        n_fail++;
        $display("FAIL pause4_lut in=%b: got %b want %b", in4, {lutk4, km4}, exp);
      end
    end
    c4_cur = c;
  endtask

  task automatic test_readback4();
    logic [16:0] c_new;
    logic [2:0]  exp;
    c_new = 17'($urandom());
    for (int j = 0; j < 17; j++) begin
      @(negedge prog_clk);
      n_tests++;
      if ({tail4, done4} !== {c4_cur[16-j], (j == 0)}) begin
        n_fail++;
        $display("FAIL readback4 j=%0d: tail/done got %b want %b", j, {tail4, done4}, {c4_cur[16-j], (j == 0)});
      end
      cfg_en4 = 1'b1;
      head4   = c_new[16-j];
      par4    = ^c_new;
    end
    @(negedge prog_clk);
    cfg_en4 = 1'b0;
    n_tests++;
    if ({done4, err4, tail4} !== {2'b10, c_new[16]}) begin
      n_fail++;
      $display("FAIL readback4_status: got %b want %b", {done4, err4, tail4}, {2'b10, c_new[16]});
    end
    for (int a = 0; a < 16; a++) begin
      in4 = 4'(a);
      #1;
      exp = ref4(c_new, in4);
      n_tests++;
      if ({lutk4, km4} !== exp) begin
        n_fail++;
        $display("FAIL readback4_lut in=%b: got %b want %b", in4, {lutk4, km4}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_and2();
    test_dual_mode();
    test_random6();
    test_parity_err();
    test_reset_mid_load();
    test_pause4();
    test_readback4();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
